// File: rtl/btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
//   Turns a raw, asynchronous push-button or switch input into a clean level
//   in the clk domain. The input is optionally inverted, passed through a
//   SYNC_STAGES-deep synchronizer, and a new level is accepted only after
//   DB_CYCLES consecutive agreeing synchronized samples. btn_out normally
//   feeds a rising-edge detector, so one physical press gives one pulse.
//
// Ports
//   clk      in   system clock, all logic on the rising edge
//   rst      in   synchronous, active-high reset
//   btn_in   in   raw asynchronous button/switch input
//   btn_out  out  debounced level (active-high after optional inversion)
//   busy     out  1 while a candidate level change is being qualified
// ----------------------------------------------------------------------------
module btn_debounce #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 1000000,
   parameter int CNT_W       = 20,
   parameter bit INVERT      = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_out,
   output logic busy
);

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      CHK_HI    = 2'd1,
      STABLE_HI = 2'd2,
      CHK_LO    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic                   s_in;
   logic [SYNC_STAGES-1:0] sync_reg;
   logic [SYNC_STAGES-1:0] sync_next;
   logic                   sync;

   state_t                 state_reg,   state_next;
   logic [CNT_W-1:0]       cnt_reg,     cnt_next;
   logic                   btn_out_reg, btn_out_next;

   assign s_in = btn_in ^ INVERT;

   // Synchronizer chain: stage 0 captures the async input, each later stage
   // takes the one before it.
   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            assign sync_next[gi] = s_in;
         end else begin : g_rest
            assign sync_next[gi] = sync_reg[gi-1];
         end
      end
   endgenerate

   assign sync = sync_reg[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg    <= '0;
         state_reg   <= STABLE_LO;
         cnt_reg     <= '0;
         btn_out_reg <= 1'b0;
      end else begin
         sync_reg    <= sync_next;
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         btn_out_reg <= btn_out_next;
      end
   end

   // The counter is cleared on every state entry, so a candidate that is
   // abandoned leaves no partial count behind for the next one.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      btn_out_next = btn_out_reg;
      case (state_reg)
         STABLE_LO: begin
            if (sync) begin
               state_next = CHK_HI;
               cnt_next   = '0;
            end
         end
         CHK_HI: begin
            if (!sync) begin
               state_next = STABLE_LO;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next   = STABLE_HI;
               cnt_next     = '0;
               btn_out_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         STABLE_HI: begin
            if (!sync) begin
               state_next = CHK_LO;
               cnt_next   = '0;
            end
         end
         CHK_LO: begin
            if (sync) begin
               state_next = STABLE_HI;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next   = STABLE_LO;
               cnt_next     = '0;
               btn_out_next = 1'b0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next   = STABLE_LO;
            cnt_next     = '0;
            btn_out_next = 1'b0;
         end
      endcase
   end

   assign btn_out = btn_out_reg;
   // Decoded straight from the state flops; no path from btn_in.
   assign busy    = (state_reg == CHK_HI) || (state_reg == CHK_LO);

endmodule
